// File: rtl/clksw_ctrl.sv
// clksw_ctrl: clock-source failover controller.
// Qualifies per-source presence flags, selects the highest-priority healthy
// source and sequences a glitch-free mux switch (gate off, select, gate on).
//
// Ports:
//   clkref      reference clock (only clock, rising edge)
//   rst_n       synchronous active-low reset
//   exist       per-source presence flags (asynchronous)
//   sel         downstream clock mux select
//   clk_en      mux output clock-gate enable (ACTIVE only)
//   valid       a selected source is running (mirrors clk_en)
//   switching   high during GATE_OFF and SELECT
//   fail_pulse  one-cycle pulse when the active source is lost
//   present     synchronized exist flags
//   sw_cnt      completed switch-on count, saturating at 255
module clksw_ctrl #(
    parameter int unsigned N_CLK       = 4,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned GATE_CYCLES = 4,
    parameter string       REVERT      = "YES"
) (
    input  logic                     clkref,
    input  logic                     rst_n,
    input  logic [N_CLK-1:0]         exist,
    output logic [$clog2(N_CLK)-1:0] sel,
    output logic                     clk_en,
    output logic                     valid,
    output logic                     switching,
    output logic                     fail_pulse,
    output logic [N_CLK-1:0]         present,
    output logic [7:0]               sw_cnt
);

    localparam int unsigned SEL_W = $clog2(N_CLK);
    localparam int unsigned CNT_W = $clog2(HOLDOFF + 1);
    localparam int unsigned GC_W  = $clog2(GATE_CYCLES + 1);
    localparam bit REVERT_EN      = (REVERT == "YES");

    typedef enum logic [1:0] {
        ST_NONE,
        ST_SELECT,
        ST_ACTIVE,
        ST_GATE_OFF
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GC_W-1:0]  gcnt;
    logic [GC_W-1:0]  gcnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             fail_nxt;
    logic [7:0]       sw_cnt_nxt;

    logic [N_CLK-1:0] sync1;
    logic [CNT_W-1:0] qcnt [N_CLK];
    logic [N_CLK-1:0] qual;
    logic [SEL_W-1:0] target;
    logic             any_qual;

    // Two-flop synchronizer; second stage is the status output.
    always_ff @(posedge clkref) begin
        if (!rst_n) begin
            sync1   <= '0;
            present <= '0;
        end else begin
            sync1   <= exist;
            present <= sync1;
        end
    end

    // Holdoff counters: count continuous presence, saturate at HOLDOFF.
    always_ff @(posedge clkref) begin
        for (int i = 0; i < int'(N_CLK); i++) begin
            if (!rst_n || !present[i]) begin
                qcnt[i] <= '0;
            end else if (qcnt[i] != CNT_W'(HOLDOFF)) begin
                qcnt[i] <= qcnt[i] + CNT_W'(1);
            end
        end
    end

    // Loss is unfiltered: qual drops with present in the same cycle.
    always_comb begin
        for (int i = 0; i < int'(N_CLK); i++) begin
            qual[i] = present[i] && (qcnt[i] == CNT_W'(HOLDOFF));
        end
    end

    // Priority pick: lowest qualified index wins.
    always_comb begin
        target   = '0;
        any_qual = |qual;
        for (int i = int'(N_CLK) - 1; i >= 0; i--) begin
            if (qual[i]) begin
                target = SEL_W'(i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        gcnt_nxt   = gcnt;
        sel_nxt    = sel;
        fail_nxt   = 1'b0;
        sw_cnt_nxt = sw_cnt;

        case (state)
            ST_NONE: begin
                if (any_qual) begin
                    sel_nxt   = target;
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!present[sel]) begin
                    state_nxt = ST_GATE_OFF;
                end else if (gcnt == '0) begin
                    state_nxt = ST_ACTIVE;
                    if (sw_cnt != 8'hFF) begin
                        sw_cnt_nxt = sw_cnt + 8'd1;
                    end
                end else begin
                    gcnt_nxt = gcnt - GC_W'(1);
                end
            end
            ST_ACTIVE: begin
                // Loss takes precedence over revert.
                if (!present[sel]) begin
                    fail_nxt  = 1'b1;
                    state_nxt = ST_GATE_OFF;
                end else if (REVERT_EN && any_qual && (target < sel)) begin
                    state_nxt = ST_GATE_OFF;
                end
            end
            ST_GATE_OFF: begin
                if (gcnt == '0) begin
                    if (any_qual) begin
                        sel_nxt   = target;
                        state_nxt = ST_SELECT;
                    end else begin
                        state_nxt = ST_NONE;
                    end
                end else begin
                    gcnt_nxt = gcnt - GC_W'(1);
                end
            end
            default: begin
                state_nxt = ST_NONE;
            end
        endcase

        // Phase counter reloads on every state entry.
        if (state_nxt != state) begin
            gcnt_nxt = GC_W'(GATE_CYCLES - 1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clkref) begin
        if (!rst_n) begin
            state      <= ST_NONE;
            gcnt       <= '0;
            sel        <= '0;
            clk_en     <= 1'b0;
            valid      <= 1'b0;
            switching  <= 1'b0;
            fail_pulse <= 1'b0;
            sw_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            gcnt       <= gcnt_nxt;
            sel        <= sel_nxt;
            clk_en     <= (state_nxt == ST_ACTIVE);
            valid      <= (state_nxt == ST_ACTIVE);
            switching  <= (state_nxt == ST_SELECT) || (state_nxt == ST_GATE_OFF);
            fail_pulse <= fail_nxt;
            sw_cnt     <= sw_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_clksw_ctrl.sv
// Directed bench for clksw_ctrl: one revert-enabled instance and one with
// revert disabled, stepped on falling edges with hand-computed expectations.
module tb_clksw_ctrl;

    logic       clkref = 1'b0;
    always #5 clkref = ~clkref;

    logic       rst_n, rst_nr;
    logic [3:0] exist, exist_nr;
    logic [1:0] sel, sel_nr;
    logic       clk_en, valid, switching, fail_pulse;
    logic       clk_en_nr, valid_nr, switching_nr, fail_pulse_nr;
    logic [3:0] present, present_nr;
    logic [7:0] sw_cnt, sw_cnt_nr;

    int errors = 0;
    int checks = 0;

    clksw_ctrl #(.N_CLK(4), .HOLDOFF(16), .GATE_CYCLES(4), .REVERT("YES")) dut (
        .clkref(clkref), .rst_n(rst_n), .exist(exist), .sel(sel),
        .clk_en(clk_en), .valid(valid), .switching(switching),
        .fail_pulse(fail_pulse), .present(present), .sw_cnt(sw_cnt)
    );

    clksw_ctrl #(.N_CLK(4), .HOLDOFF(16), .GATE_CYCLES(4), .REVERT("NO")) dut_nr (
        .clkref(clkref), .rst_n(rst_nr), .exist(exist_nr), .sel(sel_nr),
        .clk_en(clk_en_nr), .valid(valid_nr), .switching(switching_nr),
        .fail_pulse(fail_pulse_nr), .present(present_nr), .sw_cnt(sw_cnt_nr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkref);
    endtask

    // Wait (bounded) until the revert instance is ACTIVE on source s.
    task automatic wait_act(input logic [1:0] s);
        int k;
        k = 0;
        while (!(clk_en === 1'b1 && sel === s) && k < 200) begin
            step(1);
            k++;
        end
        chk("wait_active", 32'(clk_en === 1'b1 && sel === s), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; exist = 4'b0000;
        rst_nr = 1'b0; exist_nr = 4'b0000;
        step(3);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_switching", 32'(switching), 32'd0);
        chk("rst_fail", 32'(fail_pulse), 32'd0);
        chk("rst_sw_cnt", 32'(sw_cnt), 32'd0);
        chk("rst_present", 32'(present), 32'd0);

        // 1: startup on source 1
        rst_n = 1'b1; exist = 4'b0110;
        step(1);
        chk("t1_present_e1", 32'(present), 32'h0);
        step(1);
        chk("t1_present_e2", 32'(present), 32'h6);
        step(16);
        chk("t1_none_switching", 32'(switching), 32'd0);
        step(1);
        chk("t1_sel_switching", 32'(switching), 32'd1);
        chk("t1_sel_sel", 32'(sel), 32'd1);
        chk("t1_sel_clk_en", 32'(clk_en), 32'd0);
        step(3);
        chk("t1_sel_end_clk_en", 32'(clk_en), 32'd0);
        step(1);
        chk("t1_act_clk_en", 32'(clk_en), 32'd1);
        chk("t1_act_valid", 32'(valid), 32'd1);
        chk("t1_act_switching", 32'(switching), 32'd0);
        chk("t1_act_sw_cnt", 32'(sw_cnt), 32'd1);

        // 2: loss of source 1, failover to source 2
        exist = 4'b0100;
        step(1);
        chk("t2_e_clk_en", 32'(clk_en), 32'd1);
        step(1);
        chk("t2_e1_clk_en", 32'(clk_en), 32'd1);
        chk("t2_e1_fail", 32'(fail_pulse), 32'd0);
        step(1);
        chk("t2_e2_fail", 32'(fail_pulse), 32'd1);
        chk("t2_e2_clk_en", 32'(clk_en), 32'd0);
        chk("t2_e2_sel", 32'(sel), 32'd1);
        step(1);
        chk("t2_fail_once", 32'(fail_pulse), 32'd0);
        step(3);
        chk("t2_sel2", 32'(sel), 32'd2);
        chk("t2_sel_switching", 32'(switching), 32'd1);
        step(3);
        chk("t2_low8_clk_en", 32'(clk_en), 32'd0);
        step(1);
        chk("t2_act_clk_en", 32'(clk_en), 32'd1);
        chk("t2_act_sw_cnt", 32'(sw_cnt), 32'd2);

        // 3: short pulse on source 0 does not preempt; long one reverts
        exist = 4'b0101;
        step(10);
        chk("t3_short_sel", 32'(sel), 32'd2);
        exist = 4'b0100;
        step(4);
        chk("t3_short_clk_en", 32'(clk_en), 32'd1);
        chk("t3_short_switching", 32'(switching), 32'd0);
        chk("t3_short_fail", 32'(fail_pulse), 32'd0);
        exist = 4'b0101;
        step(18);
        chk("t3_preq_clk_en", 32'(clk_en), 32'd1);
        chk("t3_preq_sel", 32'(sel), 32'd2);
        step(1);
        chk("t3_rev_clk_en", 32'(clk_en), 32'd0);
        chk("t3_rev_fail", 32'(fail_pulse), 32'd0);
        chk("t3_rev_switching", 32'(switching), 32'd1);
        step(4);
        chk("t3_rev_sel", 32'(sel), 32'd0);
        step(4);
        chk("t3_act_clk_en", 32'(clk_en), 32'd1);
        chk("t3_act_sw_cnt", 32'(sw_cnt), 32'd3);

        // 5: total loss, back to NONE, then recover on source 3
        exist = 4'b0000;
        step(3);
        chk("t5_fail", 32'(fail_pulse), 32'd1);
        chk("t5_clk_en", 32'(clk_en), 32'd0);
        step(3);
        chk("t5_gate_switching", 32'(switching), 32'd1);
        step(1);
        chk("t5_none_switching", 32'(switching), 32'd0);
        chk("t5_none_clk_en", 32'(clk_en), 32'd0);
        chk("t5_none_sel", 32'(sel), 32'd0);
        exist = 4'b1000;
        step(18);
        chk("t5_wait_switching", 32'(switching), 32'd0);
        step(1);
        chk("t5_sel_switching", 32'(switching), 32'd1);
        chk("t5_sel3", 32'(sel), 32'd3);
        step(4);
        chk("t5_act_clk_en", 32'(clk_en), 32'd1);
        chk("t5_act_sel", 32'(sel), 32'd3);
        chk("t5_act_sw_cnt", 32'(sw_cnt), 32'd4);

        // 6a: drop selected source during SELECT
        exist = 4'b1001;
        step(18);
        chk("t6a_preq_clk_en", 32'(clk_en), 32'd1);
        step(1);
        chk("t6a_rev_fail", 32'(fail_pulse), 32'd0);
        chk("t6a_rev_clk_en", 32'(clk_en), 32'd0);
        step(4);
        chk("t6a_sel0", 32'(sel), 32'd0);
        chk("t6a_sel_switching", 32'(switching), 32'd1);
        exist = 4'b1000;
        step(3);
        chk("t6a_goff_switching", 32'(switching), 32'd1);
        chk("t6a_goff_clk_en", 32'(clk_en), 32'd0);
        chk("t6a_goff_fail", 32'(fail_pulse), 32'd0);
        chk("t6a_goff_sw_cnt", 32'(sw_cnt), 32'd4);
        chk("t6a_goff_sel", 32'(sel), 32'd0);
        step(4);
        chk("t6a_resel", 32'(sel), 32'd3);
        step(4);
        chk("t6a_act_clk_en", 32'(clk_en), 32'd1);
        chk("t6a_act_sw_cnt", 32'(sw_cnt), 32'd5);

        // 6b: reset asserted during SELECT
        exist = 4'b1001;
        step(23);
        chk("t6b_in_select", 32'(switching), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("t6b_sel", 32'(sel), 32'd0);
        chk("t6b_clk_en", 32'(clk_en), 32'd0);
        chk("t6b_valid", 32'(valid), 32'd0);
        chk("t6b_switching", 32'(switching), 32'd0);
        chk("t6b_fail", 32'(fail_pulse), 32'd0);
        chk("t6b_sw_cnt", 32'(sw_cnt), 32'd0);
        chk("t6b_present", 32'(present), 32'd0);

        // 6c: sw_cnt saturation via repeated failover/revert
        rst_n = 1'b1; exist = 4'b0011;
        wait_act(2'd0);
        chk("t6c_start_sw_cnt", 32'(sw_cnt), 32'd1);
        for (int it = 0; it < 130; it++) begin
            exist = 4'b0010;
            wait_act(2'd1);
            exist = 4'b0011;
            wait_act(2'd0);
            if (it == 99)  chk("t6c_sw_cnt_201", 32'(sw_cnt), 32'd201);
            if (it == 126) chk("t6c_sw_cnt_255", 32'(sw_cnt), 32'd255);
        end
        chk("t6c_sw_cnt_sat", 32'(sw_cnt), 32'd255);

        // 4: no-revert instance stays on source 2 until it fails
        rst_nr = 1'b1; exist_nr = 4'b0100;
        step(23);
        chk("t4_act_clk_en", 32'(clk_en_nr), 32'd1);
        chk("t4_act_sel", 32'(sel_nr), 32'd2);
        exist_nr = 4'b0101;
        step(40);
        chk("t4_hold_sel", 32'(sel_nr), 32'd2);
        chk("t4_hold_clk_en", 32'(clk_en_nr), 32'd1);
        chk("t4_hold_switching", 32'(switching_nr), 32'd0);
        chk("t4_hold_sw_cnt", 32'(sw_cnt_nr), 32'd1);
        exist_nr = 4'b0001;
        step(2);
        chk("t4_e1_clk_en", 32'(clk_en_nr), 32'd1);
        step(1);
        chk("t4_e2_fail", 32'(fail_pulse_nr), 32'd1);
        chk("t4_e2_clk_en", 32'(clk_en_nr), 32'd0);
        step(8);
        chk("t4_act0_clk_en", 32'(clk_en_nr), 32'd1);
        chk("t4_act0_sel", 32'(sel_nr), 32'd0);
        chk("t4_act0_sw_cnt", 32'(sw_cnt_nr), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
